peach_mem_arbiter: RTL



---
 rtl/peach_pkg.sv | 6 +
 rtl/peach_addr_check.sv | 20 ++
 rtl/peach_mem_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/peach_pkg.sv
// Shared types for the Peach memory arbiter: FSM states, port identifiers and word geometry.
package peach_pkg;
    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
    typedef enum logic {PORT_IF, PORT_D} arb_port_t;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/peach_addr_check.sv
// Byte-to-word address decode with misalignment and out-of-range detection.
module peach_addr_check
    import peach_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic [31:0]   addr,
    output logic [AW-1:0] word,
    output logic          err
);
    localparam int OFS = $clog2(WORD_BYTES);

    logic [31-OFS:0] full_word;

    assign full_word = addr[31:OFS];
    assign word      = full_word[AW-1:0];
    // Range test uses the full word index so high address bits cannot alias into the array.
    assign err       = (addr[OFS-1:0] != '0) || ({{OFS{1'b0}}, full_word} >= 32'(MEM_WORDS));
endmodule

// File: rtl/peach_mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between fetch and load/store ports,
// with one outstanding transaction and a fixed response latency.
module peach_mem_arbiter
    import peach_pkg::*;
#(
    parameter int  MEM_WORDS   = 4096,
    parameter int  MEM_LATENCY = 1,
    localparam int AW          = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    output logic          if_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);
    localparam int          CW       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    arb_state_t    state, state_nxt;
    arb_port_t     last_grant, owner;
    logic [CW-1:0] cnt;
    logic          err_q, store_q;
    logic          granted, resp;
    logic [31:0]   sel_addr;
    logic [AW-1:0] dec_word;
    logic          dec_err;

    peach_addr_check #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_addr_check (
        .addr (sel_addr),
        .word (dec_word),
        .err  (dec_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= PORT_IF;
            owner      <= PORT_IF;
            cnt        <= '0;
            err_q      <= 1'b0;
            store_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (granted) begin
                last_grant <= d_gnt ? PORT_D : PORT_IF;
                owner      <= d_gnt ? PORT_D : PORT_IF;
                cnt        <= CNT_INIT;
                err_q      <= dec_err;
                store_q    <= d_gnt && d_we;
            end else if (state == ARB_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        // Reset gates the grant path so nothing is accepted while reset is held.
        if (state == ARB_IDLE && !reset) begin
            if (if_req && d_req) begin
                d_gnt  = (last_grant == PORT_IF);
                if_gnt = !d_gnt;
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
        granted = if_gnt || d_gnt;
        resp    = (state == ARB_WAIT) && (cnt == '0);
        case (state)
            ARB_IDLE: if (granted) state_nxt = ARB_WAIT;
            ARB_WAIT: if (resp)    state_nxt = ARB_IDLE;
            default:               state_nxt = ARB_IDLE;
        endcase
    end

    assign sel_addr  = d_gnt ? d_addr : if_addr;
    assign mem_en    = granted && !dec_err;
    assign mem_we    = (d_gnt && d_we && !dec_err) ? d_be : 4'b0000;
    assign mem_addr  = dec_word;
    assign mem_wdata = d_wdata;

    assign if_rvalid = resp && (owner == PORT_IF);
    assign d_rvalid  = resp && (owner == PORT_D);
    assign if_err    = if_rvalid && err_q;
    assign d_err     = d_rvalid && err_q;
    assign if_rdata  = (if_rvalid && !err_q) ? mem_rdata : 32'h0;
    assign d_rdata   = (d_rvalid && !err_q && !store_q) ? mem_rdata : 32'h0;
endmodule
